mux_4x1_by_2x1: RTL and testbench

- 4:1 data selector built structurally from three 2:1 mux cells: two first-level cells on sel1, one second-level cell on sel0.
- Provides a combinational output `y` and a registered copy `y_q` for downstream synchronous logic.
- Used as a generic leaf selector in datapath steering.

---
 rtl/mux4_pkg.sv | 14 +
 rtl/mux_2x1.sv | 15 +
 rtl/mux_4x1_by_2x1.sv | 84 ++++++++
 tb/tb_mux_4x1_by_2x1.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared types and constants for the 4:1 selector.
// Select index is {sel0, sel1}.
package mux4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

    localparam logic [7:0] CHG_CNT_MAX = 8'hFF;

endpackage

// File: rtl/mux_2x1.sv
// Generic 2:1 mux cell, the building block of the 4:1 selector.
// An X select merges equal candidates and yields X otherwise.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // Plain conditional keeps native X-merge semantics
    assign y = s ? b : a;

endmodule

// File: rtl/mux_4x1_by_2x1.sv
// 4:1 selector from three 2:1 cells, with a registered output copy.
// Optional select-change counter enabled by MUX_SEL_CHANGE_CNT_EN.
import mux4_pkg::*;

module mux_4x1_by_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel0,
    input  logic             sel1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
`ifdef MUX_SEL_CHANGE_CNT_EN
    ,
    output logic [7:0]       sel_chg_cnt
`endif
);

    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;

    mux_2x1 #(.WIDTH(WIDTH)) u_lo (
        .a (i0),
        .b (i1),
        .s (sel1),
        .y (w_lo)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_hi (
        .a (i2),
        .b (i3),
        .s (sel1),
        .y (w_hi)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_out (
        .a (w_lo),
        .b (w_hi),
        .s (sel0),
        .y (w_y)
    );

    assign y   = w_y;
    assign y_q = r_y_q;

    // Register the selected data one cycle later, cleared in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_y;
        end
    end

`ifdef MUX_SEL_CHANGE_CNT_EN
    sel_t       w_sel;
    sel_t       r_sel_q;
    logic [7:0] r_sel_chg_cnt;

    assign w_sel       = {sel0, sel1};
    assign sel_chg_cnt = r_sel_chg_cnt;

    // Count edges where the select differs from last cycle, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_q       <= SEL_I0;
            r_sel_chg_cnt <= '0;
        end else begin
            r_sel_q <= w_sel;
            if ((w_sel != r_sel_q) && (r_sel_chg_cnt != CHG_CNT_MAX)) begin
                r_sel_chg_cnt <= r_sel_chg_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_4x1_by_2x1.sv
// Self-checking bench for mux_4x1_by_2x1 with a behavioural model.
// Counter checks compile in when MUX_SEL_CHANGE_CNT_EN is defined.
module tb_mux_4x1_by_2x1;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         sel0;
    logic         sel1;
    logic [W-1:0] d [4];
    logic [W-1:0] y;
    logic [W-1:0] y_q;
`ifdef MUX_SEL_CHANGE_CNT_EN
    logic [7:0]   sel_chg_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] m_yq;
    int           m_cnt;
    int           m_psel;

    mux_4x1_by_2x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel0  (sel0),
        .sel1  (sel1),
        .i0    (d[0]),
        .i1    (d[1]),
        .i2    (d[2]),
        .i3    (d[3]),
        .y     (y),
        .y_q   (y_q)
`ifdef MUX_SEL_CHANGE_CNT_EN
        ,
        .sel_chg_cnt (sel_chg_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_y();
        int idx;
        idx = (sel0 ? 2 : 0) + (sel1 ? 1 : 0);
        return d[idx];
    endfunction

    // Behavioural model: index the data array, delay by one edge
    always @(posedge clk) begin
        int s;
        s = (sel0 ? 2 : 0) + (sel1 ? 1 : 0);
        if (!rst_n) begin
            m_yq   <= '0;
            m_cnt  <= 0;
            m_psel <= 0;
        end else begin
            m_yq   <= model_y();
            m_psel <= s;
            if (s != m_psel && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
    end

    task automatic set_pattern(input logic [3:0] p);
        for (int k = 0; k < 4; k++) d[k] = {{(W-1){1'b0}}, p[k]};
    endtask

    task automatic test_comb();
        logic [3:0]   exp_bits;
        logic [W-1:0] exp;
        exp_bits = 4'b0101;
        set_pattern(4'h5);
        for (int s = 0; s < 4; s++) begin
            {sel0, sel1} = 2'(s);
            #5;
            exp = {{(W-1){1'b0}}, exp_bits[s]};
            checks++;
            if (y !== exp) begin
                errors++;
                $display("FAIL comb_sel%0d: got %h want %h", s, y, exp);
            end
        end
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 4; k++) d[k] = W'($urandom);
            {sel0, sel1} = 2'($urandom_range(0, 3));
            #1;
            checks++;
            if (y !== model_y()) begin
                errors++;
                $display("FAIL comb_rand: got %h want %h", y, model_y());
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_pattern(4'h5);
        {sel0, sel1} = 2'b00;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (y_q !== '0 || y !== W'(1)) begin
                errors++;
                $display("FAIL reset_hold: y_q=%h y=%h want 0/1", y_q, y);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (y_q !== W'(1)) begin
            errors++;
            $display("FAIL reset_release: got %h want 1", y_q);
        end
    endtask

    task automatic test_pipeline();
        logic [3:0] exp_q;
        exp_q = 4'b1010;
        set_pattern(4'hA);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            {sel0, sel1} = 2'(s);
            @(posedge clk); #1;
            checks++;
            if (y_q !== {{(W-1){1'b0}}, exp_q[s]}) begin
                errors++;
                $display("FAIL pipe_step%0d: got %h want %0d", s, y_q, exp_q[s]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        set_pattern(4'h0);
        {sel0, sel1} = 2'b10;
        @(posedge clk); #1;
        d[2] = W'(1);
        #1;
        checks++;
        if (y !== W'(1) || y_q !== '0) begin
            errors++;
            $display("FAIL hold_mid: y=%h y_q=%h want 1/0", y, y_q);
        end
        @(posedge clk); #1;
        checks++;
        if (y_q !== W'(1)) begin
            errors++;
            $display("FAIL hold_edge: got %h want 1", y_q);
        end
        d[0] = 8'hFF; d[1] = 8'h3C; d[3] = 8'h77;
        #1;
        checks++;
        if (y !== W'(1)) begin
            errors++;
            $display("FAIL hold_others: got %h want 1", y);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 15) != 0);
            {sel0, sel1} = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) d[k] = W'($urandom);
            #1;
            checks++;
            if (y !== model_y()) begin
                errors++;
                $display("FAIL rand_y: got %h want %h", y, model_y());
            end
            @(posedge clk); #1;
            checks++;
            if (y_q !== m_yq) begin
                errors++;
                $display("FAIL rand_yq: got %h want %h", y_q, m_yq);
            end
`ifdef MUX_SEL_CHANGE_CNT_EN
            checks++;
            if (int'(sel_chg_cnt) != m_cnt) begin
                errors++;
                $display("FAIL rand_cnt: got %0d want %0d", sel_chg_cnt, m_cnt);
            end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef MUX_SEL_CHANGE_CNT_EN
    task automatic test_cnt_basic();
        logic [1:0] seq [5];
        seq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
        @(negedge clk);
        rst_n = 1'b0;
        {sel0, sel1} = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sel_chg_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_start: got %0d want 0", sel_chg_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            {sel0, sel1} = seq[k];
        end
        @(posedge clk); #1;
        checks++;
        if (sel_chg_cnt !== 8'd3) begin
            errors++;
            $display("FAIL cnt_three: got %0d want 3", sel_chg_cnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sel_chg_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_reset: got %0d want 0", sel_chg_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cnt_sat();
        @(negedge clk);
        rst_n = 1'b0;
        {sel0, sel1} = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            sel1 = ~sel1;
            @(posedge clk); #1;
            if (n == 254 || n == 255 || n == 300) begin
                checks++;
                if (int'(sel_chg_cnt) != (n < 255 ? n : 255)) begin
                    errors++;
                    $display("FAIL cnt_sat_%0d: got %0d want %0d",
                             n, sel_chg_cnt, (n < 255 ? n : 255));
                end
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        sel0  = 1'b0;
        sel1  = 1'b0;
        set_pattern(4'h0);
        test_comb();
        test_reset();
        test_pipeline();
        test_hold();
        test_random();
`ifdef MUX_SEL_CHANGE_CNT_EN
        test_cnt_basic();
        test_cnt_sat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
